muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_negate.sv | 13 +
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and small op-decoding helpers.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Divide ops have the high op bit set.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Signed variants have the low op bit clear.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
// Used for operand magnitudes on entry and for sign fix-up of results.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide.
// One bit per cycle on magnitudes; signs are applied in a single FIX cycle.
// Both datapaths share a WIDTH+1-bit adder/subtractor and a 2*WIDTH shift register.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;   // product / quotient sign
    logic                 neg_hi_q, neg_hi_d;   // remainder sign
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   sreg_q, sreg_d;       // {acc/rem, multiplier/quotient}
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    // Operand magnitudes taken straight from the inputs at the accepting edge.
    logic                 sgn_in;
    logic                 neg_a_in, neg_b_in;
    logic [WIDTH-1:0]     abs_a, abs_b;

    assign sgn_in   = op_is_signed(op);
    assign neg_a_in = sgn_in & a[WIDTH-1];
    assign neg_b_in = sgn_in & b[WIDTH-1];

    muldiv_negate #(.W(WIDTH)) u_abs_a (.neg_i(neg_a_in), .x_i(a), .y_o(abs_a));
    muldiv_negate #(.W(WIDTH)) u_abs_b (.neg_i(neg_b_in), .x_i(b), .y_o(abs_b));

    // Sign fix-up of the finished magnitudes.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    muldiv_negate #(.W(2*WIDTH)) u_fix_prod (.neg_i(neg_lo_q), .x_i(sreg_q), .y_o(prod_fix));
    muldiv_negate #(.W(WIDTH)) u_fix_quot (.neg_i(neg_lo_q), .x_i(sreg_q[WIDTH-1:0]), .y_o(quot_fix));
    muldiv_negate #(.W(WIDTH)) u_fix_rem (.neg_i(neg_hi_q), .x_i(sreg_q[2*WIDTH-1:WIDTH]), .y_o(rem_fix));

    // Shared adder/subtractor: adds for multiply, subtracts for divide.
    logic [WIDTH:0]       add_x, add_y, add_r;
    logic [2*WIDTH-1:0]   mul_step, div_step;

    // Operand selection and the one-bit iteration for each datapath.
    always_comb begin
        add_x = is_div_q ? sreg_q[2*WIDTH-1:WIDTH-1] : {1'b0, sreg_q[2*WIDTH-1:WIDTH]};
        add_y = {1'b0, opnd_q} ^ {(WIDTH+1){is_div_q}};
        add_r = add_x + add_y + {{WIDTH{1'b0}}, is_div_q};
        // Shift-add: add multiplicand when the current multiplier bit is set, then shift right.
        mul_step = sreg_q[0] ? {add_r, sreg_q[WIDTH-1:1]} : {1'b0, sreg_q[2*WIDTH-1:1]};
        // Restoring divide: keep the difference only when it did not borrow.
        div_step = add_r[WIDTH] ? {sreg_q[2*WIDTH-2:0], 1'b0}
                                : {add_r[WIDTH-1:0], sreg_q[WIDTH-2:0], 1'b1};
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        opnd_d     = opnd_q;
        sreg_d     = sreg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = (state_q == DONE);
        div_zero_d = (state_q == DONE) & dz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op_is_div(op);
                    if (op_is_div(op) && (b == '0)) begin
                        // Nothing to compute: report and leave hi/lo untouched.
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dz_d     = 1'b0;
                        cnt_d    = '0;
                        neg_lo_d = neg_a_in ^ neg_b_in;
                        neg_hi_d = neg_a_in;
                        opnd_d   = op_is_div(op) ? abs_b : abs_a;
                        sreg_d   = {{WIDTH{1'b0}}, (op_is_div(op) ? abs_a : abs_b)};
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                sreg_d = is_div_q ? div_step : mul_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            opnd_q     <= '0;
            sreg_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            opnd_q     <= opnd_d;
            sreg_q     <= sreg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: vector table plus
// hand-written sequences for held start, mid-operation reset and divide by zero.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble inputs after acceptance, wait for done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output logic busy1, output logic [W-1:0] h,
                          output logic [W-1:0] l, output logic dz, output logic done_after);
        @(negedge clock);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clock);           // accepting edge k
        @(negedge clock);
        busy1 = busy;
        start = 1'b0; op = ~o; a = ~av; b = bv ^ 32'h5A5A_0F0F;
        lat = -1;
        done_after = 1'b0;
        h = '0; l = '0; dz = 1'b0;
        if (done) lat = 0;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            @(negedge clock);
            if (done) lat = n;
        end
        if (lat >= 0) begin
            h = hi; l = lo; dz = div_zero;
            @(negedge clock);
            done_after = done;
        end
    endtask

    int           lat;
    logic         busy1, dz, done_after;
    logic [W-1:0] h, l;
    int           exp_lat;
    int           t1, t2, dcount;

    initial begin
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[5]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[6]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
        vecs[9]  = '{OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[10] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[12] = '{OP_DIVU,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[13] = '{OP_DIVU,  32'h00000007, 32'h00000003, 32'h00000001, 32'h00000002, 1'b0};
        // Divide by zero: result registers keep hi=1, lo=2 from the line above.
        vecs[14] = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h00000001, 32'h00000002, 1'b1};
        vecs[15] = '{OP_DIV,   32'hFFFFFFF0, 32'h00000000, 32'h00000001, 32'h00000002, 1'b1};

        // Power-on reset, checked while reset is still asserted.
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dz",   64'(div_zero), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven operations.
        for (int i = 0; i < NV; i++) begin
            exp_lat = vecs[i].dz ? 1 : W + 2;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy1, h, l, dz, done_after);
            $display("vec %0d op=%0d a=%h b=%h -> lat=%0d hi=%h lo=%h dz=%0b",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, lat, h, l, dz);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
            chk($sformatf("v%0d_busy", i), 64'(busy1), 64'd1);
            chk($sformatf("v%0d_hi", i), 64'(h), 64'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(l), 64'(vecs[i].lo));
            chk($sformatf("v%0d_divzero", i), 64'(dz), 64'(vecs[i].dz));
            chk($sformatf("v%0d_done_pulse", i), 64'(done_after), 64'd0);
        end

        // Start held high: the DONE cycle must not accept it, so the second
        // completion lands WIDTH+3 cycles after the first.
        @(negedge clock);
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
        t1 = -1; t2 = -1;
        for (int n = 0; n < 200 && t2 < 0; n++) begin
            @(negedge clock);
            if (done) begin
                if (t1 < 0) t1 = n;
                else begin
                    t2 = n;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        $display("held start: done at %0d and %0d hi=%h lo=%h", t1, t2, hi, lo);
        chk("held_start_spacing", 64'(t2 - t1), 64'(W + 3));
        chk("held_start_result", {hi, lo}, 64'd15);
        repeat (W + 6) @(negedge clock);
        chk("held_start_idle", 64'(busy), 64'd0);

        // Mid-operation reset with an ignored second start while busy.
        @(negedge clock);
        start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'd2;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        start = 1'b1; op = OP_DIVU; b = 32'd0;
        @(negedge clock);
        start = 1'b0;
        chk("rst_seq_busy_held", 64'(busy), 64'd1);
        chk("rst_seq_no_dz", 64'(div_zero), 64'd0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        $display("mid-op reset: busy=%0b hi=%h lo=%h done=%0b", busy, hi, lo, done);
        chk("rst_seq_busy", 64'(busy), 64'd0);
        chk("rst_seq_hilo", {hi, lo}, 64'd0);
        chk("rst_seq_done", 64'(done), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        dcount = 0;
        for (int n = 0; n < W + 6; n++) begin
            @(negedge clock);
            if (done) dcount++;
        end
        chk("rst_seq_no_done", 64'(dcount), 64'd0);
        chk("rst_seq_idle", 64'(busy), 64'd0);

        run_op(OP_DIVU, 32'd100, 32'd7, lat, busy1, h, l, dz, done_after);
        $display("after reset DIVU 100/7 -> lat=%0d hi=%h lo=%h dz=%0b", lat, h, l, dz);
        chk("post_rst_latency", 64'(lat), 64'(W + 2));
        chk("post_rst_hi", 64'(h), 64'h2);
        chk("post_rst_lo", 64'(l), 64'hE);
        chk("post_rst_dz", 64'(dz), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
